// File: rtl/game_dialog_pkg.sv
// Shared types and constants for the multi-page dialog overlay.
package game_dialog_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TYPING,
        WAIT_KEY,
        DONE
    } dialog_state_t;

    localparam int unsigned CHAR_W  = 8;
    localparam int unsigned CHAR_H  = 16;
    localparam int unsigned COORD_W = 11;
    localparam int unsigned RGB_W   = 12;

    typedef struct packed {
        logic [COORD_W-1:0] hcount;
        logic [COORD_W-1:0] vcount;
        logic               hsync;
        logic               vsync;
        logic               hblnk;
        logic               vblnk;
    } vga_tim_t;

endpackage

// File: rtl/dialog_text_rom.sv
// Synchronous dialog text ROM: {page,line,col} -> 7-bit character code, 1 clk latency.
module dialog_text_rom #(
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [6:0]        char_code
);

    // Text content is a fixed scramble of the address so each page/line/col is distinct.
    always_ff @(posedge clk) begin
        char_code <= 7'(addr) ^ 7'h55;
    end

endmodule

// File: rtl/font_rom.sv
// Synchronous 8x16 glyph ROM: {char_code[6:0], row[3:0]} -> 8 pixels, MSB leftmost, 1 clk latency.
module font_rom (
    input  logic        clk,
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    // Procedural glyph set: top and bottom rows blank, body derived from code and row.
    always_ff @(posedge clk) begin
        if (addr[3:0] == 4'd0 || addr[3:0] == 4'd15)
            data <= '0;
        else
            data <= {addr[10:4], 1'b1} ^ {addr[3:0], addr[3:0]};
    end

endmodule

// File: rtl/game_dialog_overlay.sv
// Multi-page typewriter dialog box overlaid on the VGA stream; asserts door after the last page.
// Optional DIALOG_SKIP_EN: key[0] in TYPING reveals the whole page at once.
module game_dialog_overlay
    import game_dialog_pkg::*;
#(
    parameter int unsigned N_PAGES        = 4,
    parameter int unsigned N_LINES        = 2,
    parameter int unsigned CHARS_PER_LINE = 16,
    parameter logic [10:0] BOX_X          = 11'd64,
    parameter logic [10:0] BOX_Y          = 11'd400,
    parameter int unsigned REVEAL_DIV     = 4,
    parameter logic [3:0]  TRIGGER_PIX    = 4'd3,
    parameter logic [11:0] TXT_RGB        = 12'hFFF,
    parameter logic [11:0] BG_RGB         = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key,
    input  logic [3:0]  current_pix,
    input  logic [10:0] in_hcount,
    input  logic [10:0] in_vcount,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_hblnk,
    input  logic        in_vblnk,
    input  logic [11:0] in_rgb,
    output logic [10:0] out_hcount,
    output logic [10:0] out_vcount,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_hblnk,
    output logic        out_vblnk,
    output logic [11:0] out_rgb,
    output logic        door
);

    localparam int unsigned N_CHARS = N_LINES * CHARS_PER_LINE;
    localparam int unsigned PAGE_W  = (N_PAGES > 1) ? $clog2(N_PAGES) : 1;
    localparam int unsigned LINE_W  = (N_LINES > 1) ? $clog2(N_LINES) : 1;
    localparam int unsigned COL_W   = (CHARS_PER_LINE > 1) ? $clog2(CHARS_PER_LINE) : 1;
    localparam int unsigned REV_W   = $clog2(N_CHARS + 1);
    localparam int unsigned DIV_W   = (REVEAL_DIV > 1) ? $clog2(REVEAL_DIV) : 1;
    localparam int unsigned ROM_AW  = PAGE_W + LINE_W + COL_W;
    localparam logic [COORD_W-1:0] BOX_X_END = BOX_X + COORD_W'(CHAR_W * CHARS_PER_LINE);
    localparam logic [COORD_W-1:0] BOX_Y_END = BOX_Y + COORD_W'(CHAR_H * N_LINES);
    localparam logic [REV_W-1:0]   REV_MAX   = REV_W'(N_CHARS);

    dialog_state_t     state, state_nx;
    logic [PAGE_W-1:0] page, page_nx;
    logic [REV_W-1:0]  reveal, reveal_nx;
    logic [DIV_W-1:0]  div_cnt, div_nx;
    logic              door_nx;
    logic              key_q, vsync_q;
    logic              key_edge, frame_tick;

    logic unused_key;
    assign unused_key = ^key[3:1];

    assign key_edge   = key[0] & ~key_q;
    assign frame_tick = in_vsync & ~vsync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            page    <= '0;
            reveal  <= '0;
            div_cnt <= '0;
            door    <= 1'b0;
            key_q   <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            state   <= state_nx;
            page    <= page_nx;
            reveal  <= reveal_nx;
            div_cnt <= div_nx;
            door    <= door_nx;
            key_q   <= key[0];
            vsync_q <= in_vsync;
        end
    end

    // Priority inside an active dialog: abort, then key, then reveal-complete, then frame tick.
    always_comb begin
        state_nx  = state;
        page_nx   = page;
        reveal_nx = reveal;
        div_nx    = div_cnt;
        door_nx   = door;
        case (state)
            IDLE: begin
                if (current_pix == TRIGGER_PIX && !door) begin
                    state_nx  = TYPING;
                    page_nx   = '0;
                    reveal_nx = '0;
                    div_nx    = '0;
                end
            end
            TYPING, WAIT_KEY: begin
                if (current_pix != TRIGGER_PIX) begin
                    state_nx  = IDLE;
                    page_nx   = '0;
                    reveal_nx = '0;
                    div_nx    = '0;
                end else if (state == WAIT_KEY) begin
                    if (key_edge) begin
                        if (page < PAGE_W'(N_PAGES - 1)) begin
                            state_nx  = TYPING;
                            page_nx   = page + PAGE_W'(1);
                            reveal_nx = '0;
                            div_nx    = '0;
                        end else begin
                            state_nx = DONE;
                            door_nx  = 1'b1;
                        end
                    end
`ifdef DIALOG_SKIP_EN
                end else if (key_edge) begin
                    state_nx  = WAIT_KEY;
                    reveal_nx = REV_MAX;
`endif
                end else if (reveal == REV_MAX) begin
                    state_nx = WAIT_KEY;
                end else if (frame_tick) begin
                    if (div_cnt == DIV_W'(REVEAL_DIV - 1)) begin
                        div_nx    = '0;
                        reveal_nx = reveal + REV_W'(1);
                    end else begin
                        div_nx = div_cnt + DIV_W'(1);
                    end
                end
            end
            DONE:    door_nx = 1'b1;
            default: state_nx = IDLE;
        endcase
    end

    // S0: region test and text lookup address.
    logic [COORD_W-1:0] h_off, v_off;
    logic [COL_W-1:0]   col;
    logic [LINE_W-1:0]  line;
    logic [3:0]         row;
    logic [REV_W-1:0]   idx;
    logic               box_hit;

    always_comb begin
        h_off   = in_hcount - BOX_X;
        v_off   = in_vcount - BOX_Y;
        col     = COL_W'(h_off >> 3);
        line    = LINE_W'(v_off >> 4);
        row     = v_off[3:0];
        idx     = REV_W'(line) * REV_W'(CHARS_PER_LINE) + REV_W'(col);
        box_hit = (in_hcount >= BOX_X) && (in_hcount < BOX_X_END) &&
                  (in_vcount >= BOX_Y) && (in_vcount < BOX_Y_END) &&
                  !in_hblnk && !in_vblnk &&
                  (state == TYPING || state == WAIT_KEY);
    end

    logic [6:0] char_code;
    logic [7:0] font_data;

    dialog_text_rom #(
        .ADDR_W (ROM_AW)
    ) u_text_rom (
        .clk       (clk),
        .addr      ({page, line, col}),
        .char_code (char_code)
    );

    vga_tim_t         tim_d1, tim_d2;
    logic [RGB_W-1:0] rgb_d1, rgb_d2;
    logic             box_d1, box_d2;
    logic [REV_W-1:0] idx_d1, idx_d2;
    logic [3:0]       row_d1;

    font_rom u_font_rom (
        .clk  (clk),
        .addr ({char_code, row_d1}),
        .data (font_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            tim_d1 <= '0;
            tim_d2 <= '0;
            rgb_d1 <= '0;
            rgb_d2 <= '0;
            box_d1 <= 1'b0;
            box_d2 <= 1'b0;
            idx_d1 <= '0;
            idx_d2 <= '0;
            row_d1 <= '0;
        end else begin
            tim_d1 <= '{hcount: in_hcount, vcount: in_vcount, hsync: in_hsync,
                        vsync: in_vsync, hblnk: in_hblnk, vblnk: in_vblnk};
            rgb_d1 <= in_rgb;
            box_d1 <= box_hit;
            idx_d1 <= idx;
            row_d1 <= row;
            tim_d2 <= tim_d1;
            rgb_d2 <= rgb_d1;
            box_d2 <= box_d1;
            idx_d2 <= idx_d1;
        end
    end

    // Both ROM latencies consume the two pipeline clocks, so the final colour select is
    // a mux over stage-2 registers only.
    logic pix_bit;
    assign pix_bit = font_data[~tim_d2.hcount[2:0]];

    always_comb begin
        out_rgb = rgb_d2;
        if (box_d2)
            out_rgb = (pix_bit && idx_d2 < reveal) ? TXT_RGB : BG_RGB;
    end

    assign out_hcount = tim_d2.hcount;
    assign out_vcount = tim_d2.vcount;
    assign out_hsync  = tim_d2.hsync;
    assign out_vsync  = tim_d2.vsync;
    assign out_hblnk  = tim_d2.hblnk;
    assign out_vblnk  = tim_d2.vblnk;

endmodule

// File: tb/tb_game_dialog_overlay.sv
// Directed self-checking bench for game_dialog_overlay (works with or without DIALOG_SKIP_EN).
`timescale 1ns/1ps
module tb_game_dialog_overlay;
    import game_dialog_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  key = '0;
    logic [3:0]  current_pix = '0;
    logic [10:0] in_hcount = '0, in_vcount = '0;
    logic        in_hsync = 1'b0, in_vsync = 1'b0, in_hblnk = 1'b0, in_vblnk = 1'b0;
    logic [11:0] in_rgb = '0;
    logic [10:0] out_hcount, out_vcount;
    logic        out_hsync, out_vsync, out_hblnk, out_vblnk;
    logic [11:0] out_rgb;
    logic        door;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    int unsigned exp_page   = 0;
    int unsigned exp_reveal = 0;
    bit          exp_active = 0;

    logic [11:0] pend_rgb;
    logic [26:0] pend_tim;
    bit          pend_valid = 0;

    game_dialog_overlay dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .current_pix (current_pix),
        .in_hcount   (in_hcount),
        .in_vcount   (in_vcount),
        .in_hsync    (in_hsync),
        .in_vsync    (in_vsync),
        .in_hblnk    (in_hblnk),
        .in_vblnk    (in_vblnk),
        .in_rgb      (in_rgb),
        .out_hcount  (out_hcount),
        .out_vcount  (out_vcount),
        .out_hsync   (out_hsync),
        .out_vsync   (out_vsync),
        .out_hblnk   (out_hblnk),
        .out_vblnk   (out_vblnk),
        .out_rgb     (out_rgb),
        .door        (door)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] font_model(input logic [6:0] code, input int unsigned row);
        if (row == 0 || row == 15) return 8'h00;
        return 8'(((int'(code) << 1) | 1) ^ (row * 17));
    endfunction

    function automatic logic [11:0] pix_model(input int unsigned h, input int unsigned v,
                                              input logic [11:0] rgb, input bit blank);
        int unsigned col, line, row, idx;
        logic [6:0]  code;
        logic [7:0]  bits;
        if (!exp_active || blank || h < 64 || h >= 192 || v < 400 || v >= 432) return rgb;
        col  = (h - 64) / 8;
        line = (v - 400) / 16;
        row  = (v - 400) % 16;
        idx  = line * 16 + col;
        code = 7'(exp_page * 32 + line * 16 + col) ^ 7'h55;
        bits = font_model(code, row);
        return (bits[7 - (h % 8)] && idx < exp_reveal) ? 12'hFFF : 12'h000;
    endfunction

    task automatic drive_pix(input int unsigned h, input int unsigned v, input bit blank);
        logic [11:0] rgb;
        rgb       = 12'((h * 13 + v * 7) ^ 32'h5A5);
        in_hcount = 11'(h);
        in_vcount = 11'(v);
        in_hsync  = (h % 16) < 4;
        in_hblnk  = blank;
        in_vblnk  = 1'b0;
        in_vsync  = 1'b0;
        in_rgb    = rgb;
        @(posedge clk); #1;
        if (pend_valid) begin
            check("pix_rgb", 32'(out_rgb), 32'(pend_rgb));
            check("pix_timing", 32'({out_hsync, out_vsync, out_hblnk, out_vblnk, out_vcount, out_hcount}),
                  32'(pend_tim));
        end
        pend_rgb   = pix_model(h, v, rgb, blank);
        pend_tim   = {(h % 16) < 4, 1'b0, blank, 1'b0, 11'(v), 11'(h)};
        pend_valid = 1;
    endtask

    task automatic scan_rows(input int unsigned r0, input int unsigned r1,
                             input int unsigned r2, input int unsigned r3);
        int unsigned rows[4];
        rows = '{r0, r1, r2, r3};
        pend_valid = 0;
        foreach (rows[i])
            for (int unsigned h = 60; h <= 196; h++) drive_pix(h, rows[i], h == 100);
        drive_pix(0, 0, 0);
        pend_valid = 0;
    endtask

    task automatic frame_ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            in_vsync = 1'b1;
            @(posedge clk); #1;
            in_vsync = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic key_pulse();
        key[0] = 1'b1;
        @(posedge clk); #1;
        key[0] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset with busy inputs and the trigger tile present.
        rst = 1'b0; current_pix = 4'd3;
        in_hcount = 11'd100; in_vcount = 11'd410; in_rgb = 12'hABC;
        in_hsync = 1'b1; in_hblnk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb", 32'(out_rgb), 0);
        check("reset_timing", 32'({out_hsync, out_vsync, out_hblnk, out_vblnk, out_vcount, out_hcount}), 0);
        check("reset_door", 32'(door), 0);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        in_hcount = '0; in_vcount = '0; in_rgb = '0; in_hsync = 1'b0; in_hblnk = 1'b0;

        rst = 1'b1;
        @(posedge clk); #1;
        check("trig_state", 32'(dut.state), 32'(TYPING));
        check("trig_page", 32'(dut.page), 0);
        check("trig_reveal", 32'(dut.reveal), 0);

        frame_ticks(40);
        check("type_reveal10", 32'(dut.reveal), 10);
        exp_active = 1; exp_page = 0; exp_reveal = 10;
        scan_rows(400, 405, 416, 420);

        // Abort mid-typing with a partly advanced divider.
        frame_ticks(2);
        current_pix = 4'd0;
        @(posedge clk); #1;
        check("abort_state", 32'(dut.state), 32'(IDLE));
        check("abort_reveal", 32'(dut.reveal), 0);
        check("abort_door", 32'(door), 0);
        exp_active = 0;
        frame_ticks(1);
        scan_rows(400, 410, 420, 431);

        current_pix = 4'd3;
        @(posedge clk); #1;
        check("retrig_state", 32'(dut.state), 32'(TYPING));
        check("retrig_page", 32'(dut.page), 0);
        check("retrig_reveal", 32'(dut.reveal), 0);
        frame_ticks(3);
        check("div_cleared", 32'(dut.reveal), 0);
        frame_ticks(1);
        check("div_first", 32'(dut.reveal), 1);
        frame_ticks(16);
        check("pre_skip_reveal", 32'(dut.reveal), 5);

        key_pulse();
`ifdef DIALOG_SKIP_EN
        check("skip_reveal", 32'(dut.reveal), 32);
        check("skip_state", 32'(dut.state), 32'(WAIT_KEY));
`else
        check("noskip_reveal", 32'(dut.reveal), 5);
        check("noskip_state", 32'(dut.state), 32'(TYPING));
        frame_ticks(4);
        check("noskip_count", 32'(dut.reveal), 6);
        frame_ticks(104);
        check("full_state", 32'(dut.state), 32'(WAIT_KEY));
`endif
        frame_ticks(8);
        check("sat_reveal", 32'(dut.reveal), 32);
        check("sat_state", 32'(dut.state), 32'(WAIT_KEY));
        exp_active = 1; exp_page = 0; exp_reveal = 32;
        scan_rows(399, 400, 407, 415);
        scan_rows(416, 423, 431, 432);

        // Held key advances exactly one page.
        key[0] = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        check("held_page", 32'(dut.page), 1);
        check("held_state", 32'(dut.state), 32'(TYPING));
        key[0] = 1'b0;
        @(posedge clk); #1;
        frame_ticks(128);
        check("p1_state", 32'(dut.state), 32'(WAIT_KEY));
        check("p1_reveal", 32'(dut.reveal), 32);
        exp_page = 1;
        scan_rows(400, 409, 418, 430);

        // Key edge and frame tick together: the tick is dropped.
        key[0] = 1'b1; in_vsync = 1'b1;
        @(posedge clk); #1;
        key[0] = 1'b0; in_vsync = 1'b0;
        @(posedge clk); #1;
        check("p2_page", 32'(dut.page), 2);
        check("p2_reveal", 32'(dut.reveal), 0);
        frame_ticks(3);
        check("p2_div", 32'(dut.reveal), 0);
        frame_ticks(125);
        check("p2_state", 32'(dut.state), 32'(WAIT_KEY));

        key_pulse();
        check("p3_page", 32'(dut.page), 3);
        frame_ticks(128);
        check("p3_state", 32'(dut.state), 32'(WAIT_KEY));
        exp_page = 3;
        scan_rows(401, 412, 417, 429);

        key_pulse();
        check("done_state", 32'(dut.state), 32'(DONE));
        check("done_door", 32'(door), 1);
        exp_active = 0;
        scan_rows(400, 405, 420, 431);
        current_pix = 4'd0;
        repeat (5) @(posedge clk);
        #1;
        check("door_hold0", 32'(door), 1);
        current_pix = 4'd3;
        repeat (5) @(posedge clk);
        #1;
        frame_ticks(10);
        check("door_hold3", 32'(door), 1);
        check("done_sticky", 32'(dut.state), 32'(DONE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
